// File: rtl/hc595_pkg.sv
// rtl/hc595_pkg.sv - shared constants and helpers for the 74HC595 receive emulator
//
// Contents:
//   HC595_DATA_W     default frame width (bits per 595 frame)
//   CNT_W            shift-counter width for the default frame width
//   HC595_MSB_FIRST  bit order on ds: 1 = first bit sent lands in the MSB
//   sat_inc()        saturating increment used by the shift counter
package hc595_pkg;

  localparam int HC595_DATA_W    = 16;
  localparam int CNT_W           = $clog2(HC595_DATA_W + 2);
  localparam bit HC595_MSB_FIRST = 1'b1;

  // Increment that sticks at 'limit'; the limit is DATA_W+1 so an over-long
  // frame stays distinguishable from an exact one.
  function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic [7:0] limit);
    if (val >= limit) begin
      return limit;
    end
    return val + 8'd1;
  endfunction

endpackage

// File: rtl/hc595_edge_sync.sv
// rtl/hc595_edge_sync.sv - synchronizer, optional stability filter and rise detector for one 595 clock pin
//
// Optional feature macro: HC595_RX_GLITCH_FILTER_EN (adds the FILT_LEN stability filter)
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   pin   in   raw asynchronous pin (sh_cp or st_cp)
//   rise  out  one-cycle registered pulse on each accepted 0->1 transition
//
// Pin-to-rise latency is SYNC_STAGES+1 clk (plus FILT_LEN with the filter);
// the top-level ds delay line is sized to match exactly.
module hc595_edge_sync #(
  parameter int SYNC_STAGES = 2
`ifdef HC595_RX_GLITCH_FILTER_EN
  ,
  parameter int FILT_LEN    = 4
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cond;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
    end
  end

`ifdef HC595_RX_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILT_LEN + 1);

  logic           filt_q;
  logic [FCW-1:0] filt_cnt;

  // The accepted level flips only on the FILT_LEN-th consecutive sample that
  // disagrees with it; any agreeing sample restarts the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q   <= 1'b0;
      filt_cnt <= '0;
    end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FCW'(FILT_LEN - 1)) begin
      filt_q   <= sync_q[SYNC_STAGES-1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign cond = filt_q;
`else
  assign cond = sync_q[SYNC_STAGES-1];
`endif

  // Registered rise so that a level held high yields exactly one pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      rise   <= 1'b0;
    end else begin
      prev_q <= cond;
      rise   <= cond & ~prev_q;
    end
  end

endmodule

// File: rtl/hc595_rx.sv
// rtl/hc595_rx.sv - oversampling receive-side emulator of a 74HC595 (shift + storage register)
//
// Optional feature macro: HC595_RX_GLITCH_FILTER_EN (stability filter on sh_cp/st_cp,
// ds delay line lengthened by FILT_LEN)
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   ds          in   serial data pin
//   sh_cp       in   shift clock pin, ds sampled on its rise
//   st_cp       in   storage clock pin, data_out updated on its rise
//   data_out    out  storage register, last latched word
//   data_valid  out  one-cycle pulse when data_out is updated
//   frame_err   out  shift count since previous latch was not DATA_W
//   bit_cnt     out  shifts since last latch, saturating at DATA_W+1
module hc595_rx
  import hc595_pkg::*;
#(
  parameter int DATA_W      = HC595_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ds,
  input  logic                          sh_cp,
  input  logic                          st_cp,
  output logic [DATA_W-1:0]             data_out,
  output logic                          data_valid,
  output logic                          frame_err,
  output logic [$clog2(DATA_W+2)-1:0]   bit_cnt
);

  localparam int CW = $clog2(DATA_W + 2);

`ifdef HC595_RX_GLITCH_FILTER_EN
  localparam int FILT_EN = 1;
`else
  localparam int FILT_EN = 0;
`endif

  // Same length as the clock path (sync + rise register, plus filter), so the
  // ds bit used by a shift is the one present at the sh_cp pin edge.
  localparam int DS_DLY = SYNC_STAGES + 1 + FILT_EN * FILT_LEN;

  logic              sh_rise;
  logic              st_rise;
  logic [DS_DLY-1:0] ds_q;
  logic              ds_d;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [CW-1:0]     cnt_next;

`ifdef HC595_RX_GLITCH_FILTER_EN
  hc595_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sh_sync (
    .clk (clk), .rst (rst), .pin (sh_cp), .rise (sh_rise)
  );
  hc595_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_st_sync (
    .clk (clk), .rst (rst), .pin (st_cp), .rise (st_rise)
  );
`else
  hc595_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sh_sync (
    .clk (clk), .rst (rst), .pin (sh_cp), .rise (sh_rise)
  );
  hc595_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_st_sync (
    .clk (clk), .rst (rst), .pin (st_cp), .rise (st_rise)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_q <= '0;
    end else begin
      ds_q <= {ds_q[DS_DLY-2:0], ds};
    end
  end

  assign ds_d = ds_q[DS_DLY-1];

  // Bits shifted past the frame fall off the far end, like the real chip.
  generate
    if (HC595_MSB_FIRST) begin : g_msb_first
      assign shift_next = {shift_reg[DATA_W-2:0], ds_d};
    end else begin : g_lsb_first
      assign shift_next = {ds_d, shift_reg[DATA_W-1:1]};
    end
  endgenerate

  assign cnt_next = CW'(sat_inc(8'(bit_cnt), 8'(DATA_W + 1)));

  // A latch samples shift_reg before any same-cycle shift; that shift then
  // becomes bit 1 of the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      data_valid <= 1'b0;
      if (sh_rise) begin
        shift_reg <= shift_next;
      end
      if (st_rise) begin
        data_out   <= shift_reg;
        data_valid <= 1'b1;
        frame_err  <= (bit_cnt != CW'(DATA_W));
        bit_cnt    <= sh_rise ? CW'(1) : '0;
      end else if (sh_rise) begin
        bit_cnt <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_hc595_rx.sv
// tb/tb_hc595_rx.sv - directed self-checking bench for hc595_rx
module tb_hc595_rx;

  localparam int DATA_W = 16;
  localparam int CW     = $clog2(DATA_W + 2);
  localparam int HOLD   = 6;
`ifdef HC595_RX_GLITCH_FILTER_EN
  localparam int LAT    = 8;
`else
  localparam int LAT    = 4;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              ds;
  logic              sh_cp;
  logic              st_cp;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              frame_err;
  logic [CW-1:0]     bit_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hc595_rx dut (
    .clk        (clk),
    .rst        (rst),
    .ds         (ds),
    .sh_cp      (sh_cp),
    .st_cp      (st_cp),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .bit_cnt    (bit_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends n bits of val, MSB first; ds is stable across the whole sh_cp period.
  task automatic send_bits(input logic [31:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ds    = val[i];
      sh_cp = 1'b0;
      wait_clk(HOLD);
      sh_cp = 1'b1;
      wait_clk(HOLD);
      sh_cp = 1'b0;
    end
    wait_clk(HOLD);
  endtask

  // Waits for data_valid after an st_cp rise already driven, checks latency,
  // the latched word, frame_err and the one-cycle width of the pulse.
  task automatic expect_latch(input string tag, input logic [15:0] exp_data, input logic exp_fe);
    int n;
    n = 1;
    while (n <= 40) begin
      @(negedge clk);
      if (data_valid) break;
      n++;
    end
    check({tag, "_latency"}, n, LAT);
    check({tag, "_data"}, data_out, exp_data);
    check({tag, "_ferr"}, frame_err, exp_fe);
    @(negedge clk);
    check({tag, "_pulse_width"}, data_valid, 1'b0);
  endtask

  task automatic latch(input string tag, input logic [15:0] exp_data, input logic exp_fe);
    st_cp = 1'b1;
    expect_latch(tag, exp_data, exp_fe);
    wait_clk(HOLD);
    st_cp = 1'b0;
    wait_clk(HOLD);
  endtask

  initial begin
    rst   = 1'b1;
    ds    = 1'b0;
    sh_cp = 1'b0;
    st_cp = 1'b0;
    wait_clk(3);
    check("rst_data", data_out, 16'h0000);
    check("rst_valid", data_valid, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_cnt", bit_cnt, 0);
    rst = 1'b0;
    wait_clk(4);

    // Exact 16-bit frame.
    send_bits(32'h1234, 16);
    check("f1_cnt_before", bit_cnt, 16);
    latch("f1", 16'h1234, 1'b0);
    check("f1_cnt_after", bit_cnt, 0);

    // Short frame: 15 bits; old LSB of 0x1234 (0) moves to the MSB.
    send_bits(32'h5678 >> 1, 15);
    check("f2_cnt_before", bit_cnt, 15);
    latch("f2", 16'h2B3C, 1'b1);

    // Long frame: '11' then 0x5678, counter saturates at 17.
    send_bits(32'h3, 2);
    send_bits(32'h5678, 16);
    check("f3_cnt_sat", bit_cnt, 17);
    check("f3_ferr_hold", frame_err, 1'b1);
    latch("f3", 16'h5678, 1'b1);
    check("f3_cnt_after", bit_cnt, 0);

    // Simultaneous sh_cp and st_cp rise after 16 bits of 0xA5A5, 17th ds bit = 1.
    send_bits(32'hA5A5, 16);
    ds    = 1'b1;
    sh_cp = 1'b1;
    st_cp = 1'b1;
    expect_latch("f4", 16'hA5A5, 1'b0);
    wait_clk(HOLD);
    sh_cp = 1'b0;
    st_cp = 1'b0;
    wait_clk(HOLD);
    check("f4_cnt_after", bit_cnt, 1);

    // One bit since the last latch, then a latch with no bits at all.
    latch("f5", 16'h4B4B, 1'b1);
    check("f5_cnt_after", bit_cnt, 0);
    latch("f6_zero_bits", 16'h4B4B, 1'b1);

    // Reset mid-frame discards the partial bits.
    send_bits(32'hFF, 8);
    check("f7_cnt_partial", bit_cnt, 8);
    rst = 1'b1;
    wait_clk(3);
    check("f7_rst_data", data_out, 16'h0000);
    check("f7_rst_cnt", bit_cnt, 0);
    check("f7_rst_ferr", frame_err, 1'b0);
    rst = 1'b0;
    wait_clk(4);
    send_bits(32'h1234, 16);
    check("f7_cnt_before", bit_cnt, 16);
    latch("f7", 16'h1234, 1'b0);

`ifdef HC595_RX_GLITCH_FILTER_EN
    // A 2-clk sh_cp glitch is ignored; a 6-clk pulse is a real shift.
    sh_cp = 1'b1;
    wait_clk(2);
    sh_cp = 1'b0;
    wait_clk(12);
    check("glitch_cnt", bit_cnt, 0);
    sh_cp = 1'b1;
    wait_clk(6);
    sh_cp = 1'b0;
    wait_clk(12);
    check("pulse6_cnt", bit_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of stimulus expected finish before 2 ms");
    $fatal(1);
  end

endmodule
